// File: rtl/front_panel_io_if.sv
// Front-panel signal bundle: raw buttons, per-channel mode, debounced/shaped
// outputs and LED drive. Master is the integrating logic, slave is front_panel_io.
interface front_panel_io_if #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned LED_WIDTH = 8
) ();
    logic [CHANNELS-1:0]   btn_raw;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   stable;
    logic [CHANNELS-1:0]   ctrl_out;
    logic [LED_WIDTH-1:0]  led_in;
    logic [LED_WIDTH-1:0]  led_pin;

    modport master (
        output btn_raw, mode, led_in,
        input  stable, ctrl_out, led_pin
    );

    modport slave (
        input  btn_raw, mode, led_in,
        output stable, ctrl_out, led_pin
    );
endinterface

// File: rtl/front_panel_io.sv
// Push-button/switch front end: per-channel synchronizer, debouncer and
// mode-shaped control output, plus registered polarity-corrected LED drive.
module front_panel_io #(
    parameter int unsigned CHANNELS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LED_WIDTH       = 8,
    parameter int unsigned ACTIVE_LOW_LED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    front_panel_io_if.slave  io
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic LED_LOW = (ACTIVE_LOW_LED != 0);
    localparam logic [LED_WIDTH-1:0] LED_OFF = {LED_WIDTH{LED_LOW}};

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'b00,
        MODE_PRESS   = 2'b01,
        MODE_TOGGLE  = 2'b10,
        MODE_RELEASE = 2'b11
    } mode_e;

    logic [CHANNELS-1:0]  sync1_q, sync2_q;
    logic [CHANNELS-1:0]  stable_q, stable_d;
    logic [CHANNELS-1:0]  toggle_q, toggle_d;
    logic [CHANNELS-1:0]  ctrl_q, ctrl_d;
    logic [CHANNELS-1:0]  rise, fall;
    logic [CW-1:0]        cnt_q [CHANNELS];
    logic [CW-1:0]        cnt_d [CHANNELS];
    logic [LED_WIDTH-1:0] led_q;

    // Debounce: a mismatch must persist DEBOUNCE_CYCLES edges; any agreement restarts the count
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise     = stable_d & ~stable_q;
    assign fall     = ~stable_d & stable_q;
    assign toggle_d = toggle_q ^ rise;

    // Output shaping uses next-state values so pulses land on the same edge as stable
    always_comb begin
        ctrl_d = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            case (mode_e'(io.mode[2*i +: 2]))
                MODE_LEVEL:   ctrl_d[i] = stable_d[i];
                MODE_PRESS:   ctrl_d[i] = rise[i];
                MODE_TOGGLE:  ctrl_d[i] = toggle_d[i];
                MODE_RELEASE: ctrl_d[i] = fall[i];
                default:      ctrl_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            toggle_q <= '0;
            ctrl_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= io.btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            toggle_q <= toggle_d;
            ctrl_q   <= ctrl_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Reset leaves every LED dark regardless of pin polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= LED_OFF;
        end else begin
            led_q <= LED_LOW ? ~io.led_in : io.led_in;
        end
    end

    assign io.stable   = stable_q;
    assign io.ctrl_out = ctrl_q;
    assign io.led_pin  = led_q;
endmodule

// File: tb/tb_front_panel_io.sv
// Directed bench for front_panel_io: stimulus queues every expected output change
// with its edge number; a monitor pops and compares whenever outputs change.
module tb_front_panel_io;
    typedef struct {
        int         e;
        logic [7:0] st;
        logic [7:0] ct;
        logic [7:0] ld;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    logic [7:0] exp_st, exp_ct, exp_ld;
    logic [7:0] prev_st, prev_ct, prev_ld;
    logic       tog;
    int         n;

    front_panel_io_if #(.CHANNELS(8), .LED_WIDTH(8)) bus ();

    front_panel_io #(
        .CHANNELS(8), .DEBOUNCE_CYCLES(16), .LED_WIDTH(8), .ACTIVE_LOW_LED(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n = edge_n + 1;

    // Monitor: each observed output change must match the head of the queue
    always @(negedge clk) begin
        exp_t x;
        if (mon_en && ({bus.stable, bus.ctrl_out, bus.led_pin} !== {prev_st, prev_ct, prev_ld})) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change at edge %0d: stable=%h ctrl=%h led=%h, required no change",
                         edge_n, bus.stable, bus.ctrl_out, bus.led_pin);
            end else begin
                x = q.pop_front();
                if (edge_n != x.e || bus.stable !== x.st || bus.ctrl_out !== x.ct || bus.led_pin !== x.ld) begin
                    errors++;
                    $display("FAIL event: got stable=%h ctrl=%h led=%h at edge %0d, required stable=%h ctrl=%h led=%h at edge %0d",
                             bus.stable, bus.ctrl_out, bus.led_pin, edge_n, x.st, x.ct, x.ld, x.e);
                end
            end
            prev_st = bus.stable;
            prev_ct = bus.ctrl_out;
            prev_ld = bus.led_pin;
        end
    end

    task automatic push(input int e);
        q.push_back('{e, exp_st, exp_ct, exp_ld});
    endtask

    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic drive_btn(input logic [7:0] b);
        bus.btn_raw = b;
        n = edge_n;
    endtask

    initial begin
        exp_t x;
        rst_n       = 1'b0;
        bus.btn_raw = 8'h00;
        bus.mode    = 16'h00E4;   // ch0 level, ch1 press, ch2 toggle, ch3 release, ch4-7 level
        bus.led_in  = 8'h00;
        exp_st = 8'h00; exp_ct = 8'h00; exp_ld = 8'hFF; tog = 1'b0;
        wait_neg(3);
        check8("reset_stable", bus.stable, 8'h00);
        check8("reset_ctrl", bus.ctrl_out, 8'h00);
        check8("reset_led", bus.led_pin, 8'hFF);
        prev_st = 8'h00; prev_ct = 8'h00; prev_ld = 8'hFF;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_neg(2);

        // ch0 level: rise exactly 18 edges after the drive edge, then release
        drive_btn(8'h01); exp_st = 8'h01; exp_ct = 8'h01; push(n + 18);
        wait_neg(20);
        drive_btn(8'h00); exp_st = 8'h00; exp_ct = 8'h00; push(n + 18);
        wait_neg(20);

        // ch1 press-pulse: 15-cycle glitch ignored, then a real hold gives one pulse
        drive_btn(8'h02);
        wait_neg(15);
        drive_btn(8'h00);
        wait_neg(25);
        drive_btn(8'h02); exp_st = 8'h02; exp_ct = 8'h02; push(n + 18);
        exp_ct = 8'h00; push(n + 19);
        wait_neg(45);
        drive_btn(8'h00); exp_st = 8'h00; push(n + 18);
        wait_neg(20);

        // ch2 toggle: three presses -> 1, 0, 1
        for (int p = 0; p < 3; p++) begin
            drive_btn(8'h04); exp_st = 8'h04; tog = ~tog; exp_ct = tog ? 8'h04 : 8'h00; push(n + 18);
            wait_neg(20);
            drive_btn(8'h00); exp_st = 8'h00; push(n + 18);
            wait_neg(20);
        end
        bus.mode = 16'h00C4; n = edge_n; exp_ct = 8'h00; push(n + 1);
        wait_neg(5);
        bus.mode = 16'h00E4; n = edge_n; exp_ct = 8'h04; push(n + 1);
        wait_neg(5);

        // ch3 release-pulse: nothing at press, one pulse after release
        drive_btn(8'h08); exp_st = 8'h08; push(n + 18);
        wait_neg(20);
        drive_btn(8'h00); exp_st = 8'h00; exp_ct = 8'h0C; push(n + 18);
        exp_ct = 8'h04; push(n + 19);
        wait_neg(22);

        // LED polarity and all channels together
        bus.led_in = 8'hA5; n = edge_n; exp_ld = 8'h5A; push(n + 1);
        wait_neg(3);
        drive_btn(8'hFF); exp_st = 8'hFF; exp_ct = 8'hF3; push(n + 18);
        exp_ct = 8'hF1; push(n + 19);
        wait_neg(22);
        drive_btn(8'h00); exp_st = 8'h00; exp_ct = 8'h08; push(n + 18);
        exp_ct = 8'h00; push(n + 19);
        wait_neg(22);

        // Reset with ch1 held and its count at 10; full latency again after release
        drive_btn(8'h02);
        wait_neg(12);
        #1 rst_n = 1'b0;
        exp_ld = 8'hFF; push(n + 13);
        wait_neg(2);
        check8("midreset_stable", bus.stable, 8'h00);
        check8("midreset_ctrl", bus.ctrl_out, 8'h00);
        check8("midreset_led", bus.led_pin, 8'hFF);
        wait_neg(1);
        rst_n = 1'b1; n = edge_n;
        exp_ld = 8'h5A; push(n + 1);
        exp_st = 8'h02; exp_ct = 8'h02; push(n + 18);
        exp_ct = 8'h00; push(n + 19);
        wait_neg(22);
        drive_btn(8'h00); exp_st = 8'h00; push(n + 18);
        wait_neg(22);

        while (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: no output change seen, required stable=%h ctrl=%h led=%h at edge %0d",
                     x.st, x.ct, x.ld, x.e);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
